rah_uart_packer: RTL and testbench



---
 rtl/rah_uart_pkg.sv | 22 ++
 rtl/uart_rx_core.sv | 110 +++++++++++
 rtl/rah_uart_packer.sv | 98 +++++++++
 tb/tb_rah_uart_packer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rah_uart_pkg.sv
// Shared constants and types for the UART-to-RAH ingress path.
// Words are one header byte carrying the payload count, then up to five payload bytes.
package rah_uart_pkg;

    localparam int HDR_BITS      = 8;
    localparam int PAYLOAD_BYTES = 5;
    localparam int COUNT_W       = 3;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    // Header byte: the payload count is zero-extended into the top byte of the word.
    function automatic logic [HDR_BITS-1:0] rah_header(input logic [COUNT_W-1:0] count);
        return {{(HDR_BITS-COUNT_W){1'b0}}, count};
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: two-flop synchronizer, then a mid-bit sampling FSM.
// Emits a one-cycle byte_valid per good byte and a one-cycle frame_error per bad stop bit.
module uart_rx_core
    import rah_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx_pin,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_error
);

    localparam int              CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT/2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic             sync1_reg;
    logic             rx_s_reg;
    rx_state_t        state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [2:0]       bit_idx_reg;
    logic [7:0]       shift_reg;
    logic             byte_valid_reg;
    logic             frame_error_reg;

    // Flops reset to the idle-high line level so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg <= 1'b1;
            rx_s_reg  <= 1'b1;
        end else begin
            sync1_reg <= uart_rx_pin;
            rx_s_reg  <= sync1_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            bit_idx_reg     <= '0;
            shift_reg       <= '0;
            byte_valid_reg  <= 1'b0;
            frame_error_reg <= 1'b0;
        end else begin
            byte_valid_reg  <= 1'b0;
            frame_error_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (!rx_s_reg) begin
                        state_reg <= START;
                        cnt_reg   <= '0;
                    end
                end
                // Re-check the line half a bit in; a short low pulse falls back to IDLE.
                START: begin
                    if (cnt_reg == HALF_LAST) begin
                        cnt_reg     <= '0;
                        bit_idx_reg <= '0;
                        state_reg   <= rx_s_reg ? IDLE : DATA;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_reg == BIT_LAST) begin
                        cnt_reg   <= '0;
                        shift_reg <= {rx_s_reg, shift_reg[7:1]};
                        if (bit_idx_reg == 3'd7) begin
                            state_reg <= STOP;
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 1'b1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt_reg == BIT_LAST) begin
                        cnt_reg <= '0;
                        if (rx_s_reg) begin
                            byte_valid_reg <= 1'b1;
                            state_reg      <= IDLE;
                        end else begin
                            frame_error_reg <= 1'b1;
                            state_reg       <= BREAK;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                // A held-low line must return high before another start is accepted.
                BREAK: begin
                    if (rx_s_reg) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign byte_valid  = byte_valid_reg;
    assign byte_data   = shift_reg;
    assign frame_error = frame_error_reg;

endmodule

// File: rtl/rah_uart_packer.sv
// Groups received UART bytes into 48-bit RAH words (count header + 5 payload slots)
// and strobes each finished word to the encoder slot; an idle timeout flushes partial words.
module rah_uart_packer
    import rah_uart_pkg::*;
#(
    parameter int RAH_PACKET_WIDTH = 48,
    parameter int CLKS_PER_BIT     = 868,
    parameter int TIMEOUT_CYCLES   = 8680
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        uart_rx_pin,
    output logic [RAH_PACKET_WIDTH-1:0] data,
    output logic                        send_data,
    output logic                        frame_error
);

    localparam int                 PAYLOAD_W = PAYLOAD_BYTES * 8;
    localparam int                 TO_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0]    TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [COUNT_W-1:0] LAST_SLOT = COUNT_W'(PAYLOAD_BYTES - 1);

    logic       byte_valid;
    logic [7:0] byte_data;

    uart_rx_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk         (clk),
        .rst         (rst),
        .uart_rx_pin (uart_rx_pin),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .frame_error (frame_error)
    );

    logic [7:0]                  slot_reg  [PAYLOAD_BYTES];
    logic [7:0]                  slot_next [PAYLOAD_BYTES];
    logic [PAYLOAD_W-1:0]        payload_next;
    logic [COUNT_W-1:0]          fill_reg;
    logic [COUNT_W-1:0]          word_count;
    logic [TO_W-1:0]             timeout_reg;
    logic                        full_flush;
    logic                        timeout_flush;
    logic                        flush;
    logic [RAH_PACKET_WIDTH-1:0] data_reg;
    logic                        send_data_reg;

    // The incoming byte is merged into its slot before word assembly, so a
    // fifth byte lands in the emitted word in the same cycle it is accepted.
    generate
        for (genvar gi = 0; gi < PAYLOAD_BYTES; gi++) begin : g_slot
            assign slot_next[gi] = (byte_valid && fill_reg == COUNT_W'(gi)) ? byte_data : slot_reg[gi];
            assign payload_next[PAYLOAD_W-1-8*gi -: 8] = slot_next[gi];
        end
    endgenerate

    assign word_count    = fill_reg + COUNT_W'(byte_valid);
    assign full_flush    = byte_valid && (fill_reg == LAST_SLOT);
    // A byte arriving on the terminal count wins: it is appended instead.
    assign timeout_flush = !byte_valid && (fill_reg != '0) && (timeout_reg == TO_LAST);
    assign flush         = full_flush || timeout_flush;

    always_ff @(posedge clk) begin
        for (int k = 0; k < PAYLOAD_BYTES; k++) begin
            if (rst || flush) begin
                slot_reg[k] <= '0;
            end else begin
                slot_reg[k] <= slot_next[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fill_reg      <= '0;
            timeout_reg   <= '0;
            data_reg      <= '0;
            send_data_reg <= 1'b0;
        end else begin
            send_data_reg <= flush;
            if (flush) begin
                data_reg    <= RAH_PACKET_WIDTH'({rah_header(word_count), payload_next});
                fill_reg    <= '0;
                timeout_reg <= '0;
            end else if (byte_valid) begin
                fill_reg    <= word_count;
                timeout_reg <= '0;
            end else if (fill_reg != '0) begin
                timeout_reg <= timeout_reg + 1'b1;
            end
        end
    end

    assign data      = data_reg;
    assign send_data = send_data_reg;

endmodule

// File: tb/tb_rah_uart_packer.sv
// Bench for rah_uart_packer: serial bytes are driven on the pin, and a byte/word-level
// model predicts every output cycle from byte arrival times and the flush rules.
module tb_rah_uart_packer;

    localparam int CPB     = 4;
    localparam int TO      = 100;
    // Driven start edge -> byte_valid: 2 sync flops, 1 detect cycle, half a bit, then 8 data + stop bits.
    localparam int BV_LAT  = 3 + CPB/2 + 9*CPB;

    typedef struct {
        int         bv;
        logic [7:0] val;
    } rx_byte_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_pin = 1'b1;
    logic [47:0] data;
    logic        send_data;
    logic        frame_error;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    rx_byte_t    byte_q[$];
    int          fe_q[$];
    logic [7:0]  word_q[$];
    int          last_bv = 0;
    logic [47:0] exp_data = '0;
    logic        exp_send;
    logic        exp_fe;
    int          model_emits = 0;
    logic [47:0] model_last_word = '0;
    int          dut_sends = 0;
    int          dut_fe_cnt = 0;
    int          dut_last_cyc = 0;
    logic [47:0] dut_last_data = '0;

    rah_uart_packer #(
        .RAH_PACKET_WIDTH (48),
        .CLKS_PER_BIT     (CPB),
        .TIMEOUT_CYCLES   (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .uart_rx_pin (rx_pin),
        .data        (data),
        .send_data   (send_data),
        .frame_error (frame_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
        end
    endtask

    task automatic emit();
        logic [47:0] w;
        w = '0;
        w[42:40] = 3'(word_q.size());
        for (int k = 0; k < word_q.size(); k++) begin
            w[39-8*k -: 8] = word_q[k];
        end
        word_q.delete();
        exp_data        = w;
        exp_send        = 1'b1;
        model_emits++;
        model_last_word = w;
    endtask

    // Model: a byte is appended the cycle after its byte_valid; a word leaves when it
    // holds five bytes, or TO+1 cycles after its last byte if nothing arrived in time.
    always @(posedge clk) begin
        #1;
        cyc++;
        exp_send = 1'b0;
        exp_fe   = 1'b0;
        if (rst) begin
            word_q.delete();
            exp_data = '0;
        end else begin
            if (fe_q.size() > 0 && fe_q[0] == cyc) begin
                exp_fe = 1'b1;
                void'(fe_q.pop_front());
            end
            if (byte_q.size() > 0 && byte_q[0].bv == cyc - 1) begin
                word_q.push_back(byte_q[0].val);
                last_bv = cyc - 1;
                void'(byte_q.pop_front());
                if (word_q.size() == 5) emit();
            end else if (word_q.size() > 0 && cyc == last_bv + TO + 1) begin
                emit();
            end
        end
        chk("send_data", 64'(send_data), 64'(exp_send));
        chk("frame_error", 64'(frame_error), 64'(exp_fe));
        chk("data", 64'(data), 64'(exp_data));
        if (send_data === 1'b1) begin
            dut_sends++;
            dut_last_cyc  = cyc;
            dut_last_data = data;
            $display("word  cycle %0d  data=%012h", cyc, data);
        end
        if (frame_error === 1'b1) dut_fe_cnt++;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called just after a negedge; drives start, 8 data bits LSB first, stop.
    task automatic send_byte(input logic [7:0] b, input bit good);
        logic [9:0] frame;
        frame = {good, b, 1'b0};
        if (good) byte_q.push_back('{cyc + BV_LAT, b});
        else      fe_q.push_back(cyc + BV_LAT);
        for (int i = 0; i < 10; i++) begin
            rx_pin = frame[i];
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic expect_word(input string name, input int exp_cyc, input logic [47:0] exp_w);
        chk({name, "_cycle"}, 64'(dut_last_cyc), 64'(exp_cyc));
        chk({name, "_data"}, 64'(dut_last_data), 64'(exp_w));
        chk({name, "_model"}, 64'(model_last_word), 64'(exp_w));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int s0;
        int f0;
        logic [7:0] b;
        bit good;

        @(negedge clk);
        idle(5);
        chk("reset_data", 64'(data), 64'(0));
        chk("reset_send", 64'(send_data), 64'(0));
        rst = 1'b0;
        idle(10);

        // Five back-to-back bytes: full flush one cycle after the fifth byte_valid.
        n = cyc;
        send_byte(8'h11, 1); send_byte(8'h22, 1); send_byte(8'h33, 1);
        send_byte(8'h44, 1); send_byte(8'h55, 1);
        idle(20);
        expect_word("full", n + 4*40 + BV_LAT + 1, 48'h05_11_22_33_44_55);

        // Two bytes then idle: timeout flush TO+1 cycles after the second byte_valid.
        n = cyc;
        send_byte(8'hA5, 1); send_byte(8'h3C, 1);
        idle(130);
        expect_word("timeout", n + 40 + BV_LAT + TO + 1, 48'h02_A5_3C_00_00_00);

        // Bad stop bit, line held low, released, then five good bytes.
        f0 = dut_fe_cnt;
        s0 = dut_sends;
        send_byte(8'h5A, 0);
        idle(40);
        rx_pin = 1'b1;
        idle(8);
        chk("break_fe_count", 64'(dut_fe_cnt), 64'(f0 + 1));
        chk("break_no_word", 64'(dut_sends), 64'(s0));
        n = cyc;
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 1);
        idle(20);
        chk("break_one_word", 64'(dut_sends), 64'(s0 + 1));
        expect_word("break", n + 4*40 + BV_LAT + 1, 48'h05_01_02_03_04_05);

        // Two-cycle glitch on an idle line is rejected silently.
        f0 = dut_fe_cnt;
        s0 = dut_sends;
        rx_pin = 1'b0;
        idle(2);
        rx_pin = 1'b1;
        idle(60);
        chk("glitch_no_fe", 64'(dut_fe_cnt), 64'(f0));
        chk("glitch_no_word", 64'(dut_sends), 64'(s0));

        // Reset after three bytes and part of a fourth discards everything.
        s0 = dut_sends;
        send_byte(8'h0A, 1); send_byte(8'h0B, 1); send_byte(8'h0C, 1);
        rx_pin = 1'b0; idle(CPB);
        rx_pin = 1'b1; idle(CPB);
        rx_pin = 1'b0; idle(2*CPB);
        rst = 1'b1;
        rx_pin = 1'b1;
        byte_q.delete();
        fe_q.delete();
        idle(4);
        rst = 1'b0;
        idle(150);
        chk("rst_no_word", 64'(dut_sends), 64'(s0));
        chk("rst_data_zero", 64'(data), 64'(0));
        n = cyc;
        send_byte(8'hC1, 1); send_byte(8'hC2, 1); send_byte(8'hC3, 1);
        send_byte(8'hC4, 1); send_byte(8'hC5, 1);
        idle(20);
        expect_word("rst", n + 4*40 + BV_LAT + 1, 48'h05_C1_C2_C3_C4_C5);

        // Second byte_valid lands exactly on the terminal count: byte wins.
        n = cyc;
        send_byte(8'h77, 1);
        idle(TO - 40);
        send_byte(8'h88, 1);
        idle(110);
        expect_word("tie", n + TO + BV_LAT + TO + 1, 48'h02_77_88_00_00_00);

        // Byte arriving the cycle after a timeout flush starts a fresh word.
        n = cyc;
        send_byte(8'h99, 1);
        idle(TO - 40 + 1);
        send_byte(8'hAA, 1);
        idle(2);
        expect_word("after_flush_a", n + BV_LAT + TO + 1, 48'h01_99_00_00_00_00);
        idle(110);
        expect_word("after_flush_b", n + BV_LAT + 2*(TO + 1), 48'h01_AA_00_00_00_00);

        // Randomized traffic with gaps around the timeout boundary and occasional bad stops.
        for (int i = 0; i < 60; i++) begin
            b    = 8'($urandom_range(0, 255));
            good = ($urandom_range(0, 9) != 0);
            send_byte(b, good);
            if (!good) begin
                idle(int'($urandom_range(0, 20)));
                rx_pin = 1'b1;
                idle(4);
            end
            case ($urandom_range(0, 3))
                0: ;
                1: idle(int'($urandom_range(1, 30)));
                2: idle(int'($urandom_range(TO - 45, TO - 35)));
                default: idle(int'($urandom_range(120, 160)));
            endcase
        end
        idle(250);

        chk("drain_bytes", 64'(byte_q.size()), 64'(0));
        chk("drain_words", 64'(word_q.size()), 64'(0));
        chk("word_total", 64'(dut_sends), 64'(model_emits));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
